// File: rtl/keyed_mux_pkg.sv
// keyed_mux_pkg
//   Shared constants for the keyed multiplexer slice: default parameter
//   widths and the helper that derives the packed key/data pair width.
//   No ports.
package keyed_mux_pkg;

    localparam int unsigned DEF_NR_KEY   = 2;
    localparam int unsigned DEF_KEY_LEN  = 2;
    localparam int unsigned DEF_DATA_LEN = 32;

    // Width of one {key, data} pair inside the packed lut vector.
    function automatic int unsigned pair_len(input int unsigned key_len,
                                             input int unsigned data_len);
        return key_len + data_len;
    endfunction

endpackage

// File: rtl/key_mux_core.sv
// key_mux_core
//   Combinational keyed table lookup. Every pair whose key equals the
//   select key contributes its data; all contributions are OR-ed, so
//   duplicate keys merge instead of being prioritised.
// Ports
//   key        in  KEY_LEN                     select key
//   default_in in  DATA_LEN                    result when nothing matches
//   lut        in  NR_KEY*(KEY_LEN+DATA_LEN)   packed pairs, pair 0 in the LSBs
//   out        out DATA_LEN                    lookup result
//   hit        out 1                           at least one key matched
module key_mux_core
    import keyed_mux_pkg::*;
#(
    parameter int unsigned NR_KEY   = DEF_NR_KEY,
    parameter int unsigned KEY_LEN  = DEF_KEY_LEN,
    parameter int unsigned DATA_LEN = DEF_DATA_LEN
) (
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_in,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                  out,
    output logic                                 hit
);

    localparam int unsigned PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);

    logic [NR_KEY-1:0]   match;
    logic [DATA_LEN-1:0] masked [NR_KEY];

    for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_pair
        logic [KEY_LEN-1:0]  pair_key;
        logic [DATA_LEN-1:0] pair_data;

        assign pair_key    = lut[PAIR_LEN*gi+DATA_LEN +: KEY_LEN];
        assign pair_data   = lut[PAIR_LEN*gi +: DATA_LEN];
        assign match[gi]   = (key == pair_key);
        assign masked[gi]  = {DATA_LEN{match[gi]}} & pair_data;
    end

    logic [DATA_LEN-1:0] or_acc;

    always_comb begin
        or_acc = '0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            or_acc = or_acc | masked[i];
        end
    end

    assign hit = |match;

    // AND/OR select rather than ?: so an unknown key yields an unknown result
    // instead of a merged value.
    assign out = (or_acc & {DATA_LEN{hit}}) | (default_in & {DATA_LEN{~hit}});

endmodule

// File: rtl/keyed_mux_reg.sv
// keyed_mux_reg
//   Keyed table lookup (key_mux_core) followed by an enabled register.
//   mux_out is purely combinational and ignores reset/en; q loads mux_out
//   on a rising clock edge when en=1, and reset (synchronous, active-high)
//   loads RESET_VAL with priority over en.
//   Optional feature macro: KEYED_MUX_HIT_EN adds output hit_o.
// Ports
//   clock      in  1                           rising-edge clock
//   reset      in  1                           synchronous active-high reset
//   en         in  1                           register load enable
//   key        in  KEY_LEN                     select key
//   default_in in  DATA_LEN                    result when no key matches
//   lut        in  NR_KEY*(KEY_LEN+DATA_LEN)   packed key/data table
//   mux_out    out DATA_LEN                    combinational select result
//   q          out DATA_LEN                    registered select result
//   hit_o      out 1                           (KEYED_MUX_HIT_EN only) key matched
module keyed_mux_reg
    import keyed_mux_pkg::*;
#(
    parameter int unsigned          NR_KEY    = DEF_NR_KEY,
    parameter int unsigned          KEY_LEN   = DEF_KEY_LEN,
    parameter int unsigned          DATA_LEN  = DEF_DATA_LEN,
    parameter logic [DATA_LEN-1:0]  RESET_VAL = '0
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_in,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                  mux_out,
`ifdef KEYED_MUX_HIT_EN
    output logic                                 hit_o,
`endif
    output logic [DATA_LEN-1:0]                  q
);

    logic hit;

    key_mux_core #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_core (
        .key        (key),
        .default_in (default_in),
        .lut        (lut),
        .out        (mux_out),
        .hit        (hit)
    );

`ifdef KEYED_MUX_HIT_EN
    assign hit_o = hit;
`else
    // hit is only exported in the optional build.
    logic hit_unused;
    assign hit_unused = hit;
`endif

    logic [DATA_LEN-1:0] q_q;
    logic [DATA_LEN-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = mux_out;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_keyed_mux_reg.sv
module tb_keyed_mux_reg;

    localparam logic [31:0] RV = 32'hDEADBEEF;

    int total = 0;
    int bad   = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: 4 pairs, 2-bit keys, 32-bit data, registered path.
    logic         reset_a, en_a;
    logic [1:0]   key_a;
    logic [31:0]  def_a;
    logic [135:0] lut_a;
    logic [31:0]  mux_a, q_a;

    // Instance B: 3 pairs, 32-bit keys (default path).
    logic [31:0]  key_b, def_b;
    logic [191:0] lut_b;
    logic [31:0]  mux_b, q_b_unused;

    // Instance C: 2 pairs, 1-bit keys, 12-bit data (duplicates).
    logic         key_c;
    logic [11:0]  def_c;
    logic [25:0]  lut_c;
    logic [11:0]  mux_c, q_c_unused;

`ifdef KEYED_MUX_HIT_EN
    logic hit_a, hit_b, hit_c;
`endif

    keyed_mux_reg #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(32), .RESET_VAL(RV)) dut_a (
        .clock(clock), .reset(reset_a), .en(en_a), .key(key_a),
        .default_in(def_a), .lut(lut_a), .mux_out(mux_a),
`ifdef KEYED_MUX_HIT_EN
        .hit_o(hit_a),
`endif
        .q(q_a));

    keyed_mux_reg #(.NR_KEY(3), .KEY_LEN(32), .DATA_LEN(32), .RESET_VAL(32'h0)) dut_b (
        .clock(clock), .reset(1'b0), .en(1'b0), .key(key_b),
        .default_in(def_b), .lut(lut_b), .mux_out(mux_b),
`ifdef KEYED_MUX_HIT_EN
        .hit_o(hit_b),
`endif
        .q(q_b_unused));

    keyed_mux_reg #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(12), .RESET_VAL(12'h0)) dut_c (
        .clock(clock), .reset(1'b0), .en(1'b0), .key(key_c),
        .default_in(def_c), .lut(lut_c), .mux_out(mux_c),
`ifdef KEYED_MUX_HIT_EN
        .hit_o(hit_c),
`endif
        .q(q_c_unused));

    // Scoreboard of expected q values and the bench's own register model.
    logic [31:0] sb_q [$];
    logic [31:0] q_model;

    // Reference lookup for instance A: scan all pairs, OR matching data.
    function automatic logic [32:0] ref_a(input logic [135:0] l,
                                          input logic [1:0] k,
                                          input logic [31:0] d);
        logic [31:0] acc;
        logic        h;
        logic [33:0] p;
        acc = 32'h0;
        h   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p = l[i*34 +: 34];
            if (p[33:32] == k) begin
                acc = acc | p[31:0];
                h   = 1'b1;
            end
        end
        return {h, h ? acc : d};
    endfunction

    task automatic test_table_select();
        logic [31:0] va, vb, vc, vd;
        logic [1:0]  keys [3];
        logic [31:0] exps [3];
        va = 32'hAAAA_0001; vb = 32'hBBBB_0002; vc = 32'hCCCC_0003; vd = 32'hDDDD_0004;
        keys[0] = 2'b01; exps[0] = vb;
        keys[1] = 2'b11; exps[1] = vd;
        keys[2] = 2'b00; exps[2] = va;
        @(negedge clock);
        reset_a = 1'b0; en_a = 1'b0; def_a = 32'h1234_5678;
        lut_a = {2'b00, va, 2'b01, vb, 2'b10, vc, 2'b11, vd};
        for (int i = 0; i < 3; i++) begin
            key_a = keys[i];
            #1;
            total++;
            if (mux_a !== exps[i]) begin
                bad++;
                $display("FAIL table_select key=%b got=%h want=%h", keys[i], mux_a, exps[i]);
            end
        end
    endtask

    task automatic test_default();
        lut_b = {32'hffffffff, 32'h33333333, 32'h0000ffff, 32'h22222222,
                 32'h000000ff, 32'h11111111};
        key_b = 32'h12345678; def_b = 32'h0;
        #1;
        total++;
        if (mux_b !== 32'h0) begin
            bad++;
            $display("FAIL default_zero got=%h want=%h", mux_b, 32'h0);
        end
`ifdef KEYED_MUX_HIT_EN
        total++;
        if (hit_b !== 1'b0) begin
            bad++;
            $display("FAIL default_hit got=%b want=0", hit_b);
        end
`endif
        key_b = 32'h12345678; def_b = 32'h0000005a;
        #1;
        total++;
        if (mux_b !== 32'h5a) begin
            bad++;
            $display("FAIL default_val got=%h want=%h", mux_b, 32'h5a);
        end
        key_b = 32'h0000ffff;
        #1;
        total++;
        if (mux_b !== 32'h22222222) begin
            bad++;
            $display("FAIL wide_key_hit got=%h want=%h", mux_b, 32'h22222222);
        end
`ifdef KEYED_MUX_HIT_EN
        total++;
        if (hit_b !== 1'b1) begin
            bad++;
            $display("FAIL wide_key_hitflag got=%b want=1", hit_b);
        end
`endif
    endtask

    task automatic test_duplicates();
        lut_c = {1'b1, 12'h0F0, 1'b1, 12'h00F};
        def_c = 12'hABC;
        key_c = 1'b1;
        #1;
        total++;
        if (mux_c !== 12'h0FF) begin
            bad++;
            $display("FAIL duplicates got=%h want=%h", mux_c, 12'h0FF);
        end
        key_c = 1'b0;
        #1;
        total++;
        if (mux_c !== 12'hABC) begin
            bad++;
            $display("FAIL dup_default got=%h want=%h", mux_c, 12'hABC);
        end
    endtask

    // Steps: reset, load, hold, reset with en (priority), resume.
    task automatic test_reg_enable();
        logic        rst_t [5];
        logic        en_t  [5];
        logic [1:0]  key_t [5];
        logic [32:0] r;
        logic [31:0] exp_q;
        rst_t = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        en_t  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        key_t = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        @(negedge clock);
        lut_a = {2'b00, 32'h5, 2'b01, 32'h9, 2'b10, 32'h0, 2'b11, 32'h0};
        def_a = 32'h0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            reset_a = rst_t[s]; en_a = en_t[s]; key_a = key_t[s];
            #1;
            r = ref_a(lut_a, key_a, def_a);
            total++;
            if (mux_a !== r[31:0]) begin
                bad++;
                $display("FAIL reg_mux step=%0d got=%h want=%h", s, mux_a, r[31:0]);
            end
            q_model = rst_t[s] ? RV : (en_t[s] ? r[31:0] : q_model);
            sb_q.push_back(q_model);
            @(posedge clock);
            #1;
            exp_q = sb_q.pop_front();
            total++;
            if (q_a !== exp_q) begin
                bad++;
                $display("FAIL reg_q step=%0d got=%h want=%h", s, q_a, exp_q);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_a = 1'b1; en_a = 1'b1; key_a = 2'b00; def_a = 32'h0;
        lut_a = {2'b00, 32'h5, 2'b01, 32'h9, 2'b10, 32'h0, 2'b11, 32'h0};
        #1;
        total++;
        if (mux_a !== 32'h5) begin
            bad++;
            $display("FAIL reset_mux_valid got=%h want=%h", mux_a, 32'h5);
        end
        q_model = RV;
        sb_q.push_back(q_model);
        @(posedge clock);
        #1;
        total++;
        begin
            logic [31:0] exp_q;
            exp_q = sb_q.pop_front();
            if (q_a !== exp_q) begin
                bad++;
                $display("FAIL reset_q got=%h want=%h", q_a, exp_q);
            end
        end
    endtask

    task automatic test_random();
        logic [159:0] tmp;
        logic [32:0]  r;
        logic [31:0]  exp_q;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            for (int j = 0; j < 5; j++) tmp[j*32 +: 32] = $urandom;
            lut_a   = tmp[135:0];
            key_a   = 2'($urandom_range(0, 3));
            def_a   = $urandom;
            en_a    = 1'($urandom_range(0, 1));
            reset_a = ($urandom_range(0, 15) == 0);
            #1;
            r = ref_a(lut_a, key_a, def_a);
            total++;
            if (mux_a !== r[31:0]) begin
                bad++;
                $display("FAIL rand_mux cyc=%0d got=%h want=%h", i, mux_a, r[31:0]);
            end
`ifdef KEYED_MUX_HIT_EN
            total++;
            if (hit_a !== r[32]) begin
                bad++;
                $display("FAIL rand_hit cyc=%0d got=%b want=%b", i, hit_a, r[32]);
            end
`endif
            q_model = reset_a ? RV : (en_a ? r[31:0] : q_model);
            sb_q.push_back(q_model);
            @(posedge clock);
            #1;
            exp_q = sb_q.pop_front();
            total++;
            if (q_a !== exp_q) begin
                bad++;
                $display("FAIL rand_q cyc=%0d got=%h want=%h", i, q_a, exp_q);
            end
        end
    endtask

    initial begin
        reset_a = 1'b1; en_a = 1'b0; key_a = '0; def_a = '0; lut_a = '0;
        key_b = '0; def_b = '0; lut_b = '0;
        key_c = 1'b0; def_c = '0; lut_c = '0;
        q_model = RV;
        test_reset();
        test_table_select();
        test_default();
        test_duplicates();
        test_reg_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keyed_mux_reg.md
KEYED_MUX_REG -- requirements
Module: keyed_mux_reg

Interface
REQ-001 SHALL have parameter NR_KEY, default 2: number of key/data pairs, minimum 1.
REQ-002 SHALL have parameter KEY_LEN, default 2: key width in bits, minimum 1.
REQ-003 SHALL have parameter DATA_LEN, default 32: data width in bits, minimum 1.
REQ-004 SHALL have parameter RESET_VAL, default 0: value loaded into q on reset, DATA_LEN bits.
REQ-005 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: register load enable.
REQ-008 SHALL have port key, input, KEY_LEN bits: select key.
REQ-009 SHALL have port default_in, input, DATA_LEN bits: value used when no key matches.
REQ-010 SHALL have port lut, input, NR_KEY*(KEY_LEN+DATA_LEN) bits: packed key/data table.
REQ-011 SHALL have port mux_out, output, DATA_LEN bits: combinational select result.
REQ-012 SHALL have port q, output, DATA_LEN bits: registered select result.

Function
REQ-013 SHALL define PAIR_LEN = KEY_LEN+DATA_LEN; pair i SHALL occupy lut[PAIR_LEN*(i+1)-1 : PAIR_LEN*i].
REQ-014 SHALL take key_i from the upper KEY_LEN bits of pair i and data_i from the lower DATA_LEN bits; with a concatenation {k_a,d_a,k_b,d_b}, pair 0 is the last-listed pair.
REQ-015 SHALL compute hit = OR over i of (key == key_i).
REQ-016 SHALL drive mux_out = bitwise OR of data_i over every i with key == key_i when hit=1, and default_in when hit=0; zero combinational latency.
REQ-017 SHALL, on duplicate matching keys, output the bitwise OR of all matching data_i, with no priority.
REQ-018 SHALL, on each rising clock edge with reset=0 and en=1, load q <= mux_out.
REQ-019 SHALL hold q unchanged on each rising clock edge with reset=0 and en=0.
REQ-020 SHALL give q one cycle of latency from key/lut/default_in to q when en=1.
REQ-021 SHALL keep mux_out independent of reset and en.
REQ-022 SHALL propagate X/Z on key to mux_out without masking; no checks inside the block.

Reset
REQ-023 SHALL load q <= RESET_VAL on a rising edge with reset=1, regardless of en; reset SHALL take priority over en.
REQ-024 SHALL have reset abort nothing else, since there is no other state; mux_out SHALL stay valid during reset.
REQ-025 SHALL resume loading on the first edge after reset deasserts if en=1.

Configuration
REQ-026 SHALL support macro KEYED_MUX_HIT_EN; when defined, SHALL add output port hit_o (1 bit, combinational) equal to hit from REQ-015.
REQ-027 SHALL, when KEYED_MUX_HIT_EN is undefined, omit the port hit_o and leave all other behaviour identical.

Structure
REQ-028 SHALL place the shared constants (default widths, PAIR_LEN computation helper) in package keyed_mux_pkg.
REQ-029 SHALL implement the combinational table lookup as sub-module key_mux_core (parameters NR_KEY, KEY_LEN, DATA_LEN; ports key, default_in, lut, out, hit); the enabled register SHALL be inline in keyed_mux_reg.
REQ-030 SHALL implement key_mux_core with a generate loop over NR_KEY: AND-mask then OR-reduce, so there is no priority chain.

Verification
REQ-031 SHALL cover table select: NR_KEY=4, KEY_LEN=2, DATA_LEN=32, lut={2'b00,A,2'b01,B,2'b10,C,2'b11,D}; key=2'b01 -> mux_out=B; key=2'b11 -> mux_out=D.
REQ-032 SHALL cover default: NR_KEY=3, KEY_LEN=32, keys 0x000000ff/0x0000ffff/0xffffffff, key=0x12345678, default_in=0 -> mux_out=0, hit_o=0.
REQ-033 SHALL cover duplicates: two pairs both with key 1'b1 and data 0x0F0 and 0x00F, key=1 -> mux_out=0x0FF.
REQ-034 SHALL cover register enable: RESET_VAL=0xDEADBEEF; reset one cycle -> q=0xDEADBEEF; en=1 with mux_out=0x5 -> q=0x5 after one edge; en=0 with mux_out=0x9 -> q stays 0x5.
REQ-035 SHALL cover reset priority: reset=1 and en=1 on the same edge -> q=RESET_VAL.
REQ-036 SHALL cover exhaustive lookup: random lut and key over 1000 cycles -> mux_out matches the reference model every cycle, and q matches the previous cycle's mux_out when en=1.
